// File: rtl/ssc_monitor.sv
// ssc_monitor: recovers the 32-bit value, decimal points and error flags from a multiplexed seven-segment bus
module ssc_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int FRAME_CYCLES  = 131072
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  anode,
    input  logic [7:0]  segment,
    output logic [31:0] dataOut,
    output logic [7:0]  digitPointOut,
    output logic [7:0]  digitSeen,
    output logic [7:0]  digitError,
    output logic        anodeError,
    output logic        frameValid
);
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam int FW = $clog2(FRAME_CYCLES);
    localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [7:0]    anode_q, segment_q, anode_p, segment_p;
    logic [CW-1:0] stable_cnt;
    logic [FW-1:0] frame_cnt;
    logic          same, strobe, term, hit;
    logic [3:0]    nibble;
    logic [31:0]   cap_data, nxt_data;
    logic [7:0]    cap_point, cap_seen, cap_err, nxt_point, nxt_seen, nxt_err;
    logic          cap_aerr, nxt_aerr;

    assign same   = {anode_q, segment_q} == {anode_p, segment_p};
    assign strobe = same && stable_cnt == CW'(STABLE_CYCLES - 2);
    assign term   = frame_cnt == FW'(FRAME_CYCLES - 1);

    // Register the bus, keep the previous sample and count how long it has been unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            anode_q    <= '0;
            segment_q  <= '0;
            anode_p    <= '0;
            segment_p  <= '0;
            stable_cnt <= '0;
        end else begin
            anode_q    <= anode;
            segment_q  <= segment;
            anode_p    <= anode_q;
            segment_p  <= segment_q;
            stable_cnt <= !same ? '0 : stable_cnt == CW'(STABLE_CYCLES - 1) ? stable_cnt : stable_cnt + CW'(1);
        end
    end

    // Inverse glyph lookup of the settled segment pattern
    always_comb begin
        hit    = 1'b0;
        nibble = 4'h0;
        for (int k = 0; k < 16; k++) begin
            if (segment_q[6:0] == GLYPH[k]) begin
                hit    = 1'b1;
                nibble = 4'(k);
            end
        end
    end

    // Next capture state: a single low anode captures that digit, several low anodes flag an error
    always_comb begin
        nxt_data  = cap_data;
        nxt_point = cap_point;
        nxt_seen  = cap_seen;
        nxt_err   = cap_err;
        nxt_aerr  = cap_aerr;
        if (strobe && anode_q != 8'hFF) begin
            if ($onehot(~anode_q)) begin
                for (int i = 0; i < 8; i++) begin
                    if (!anode_q[i]) begin
                        nxt_data[4*i +: 4] = hit ? nibble : 4'h0;
                        nxt_point[i]       = ~segment_q[7];
                        nxt_seen[i]        = 1'b1;
                        nxt_err[i]         = ~hit;
                    end
                end
            end else begin
                nxt_aerr = 1'b1;
            end
        end
    end

    // Free-running window counter; at its end publish the captures and start a fresh window
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt     <= '0;
            frameValid    <= 1'b0;
            cap_data      <= '0;
            cap_point     <= '0;
            cap_seen      <= '0;
            cap_err       <= '0;
            cap_aerr      <= 1'b0;
            dataOut       <= '0;
            digitPointOut <= '0;
            digitSeen     <= '0;
            digitError    <= '0;
            anodeError    <= 1'b0;
        end else begin
            frame_cnt  <= term ? '0 : frame_cnt + FW'(1);
            frameValid <= term;
            cap_data   <= term ? '0 : nxt_data;
            cap_point  <= term ? '0 : nxt_point;
            cap_seen   <= term ? '0 : nxt_seen;
            cap_err    <= term ? '0 : nxt_err;
            cap_aerr   <= term ? 1'b0 : nxt_aerr;
            if (term) begin
                dataOut       <= nxt_data;
                digitPointOut <= nxt_point;
                digitSeen     <= nxt_seen;
                digitError    <= nxt_err;
                anodeError    <= nxt_aerr;
            end
        end
    end
endmodule
